universal_shift_reg: RTL and testbench

Parametrised successor to the team's 4-bit enable register. It adds a configurable width, parallel load, clear, logical and arithmetic shifts, rotates and serial in/out. It also supports a multi-cycle burst shift of N positions with busy/done handshake. It serves as the general-purpose data register in datapath and serialiser blocks.

---
 rtl/usr_pkg.sv | 30 +++
 rtl/usr_shift_step.sv | 52 +++++
 rtl/universal_shift_reg.sv | 140 ++++++++++++++
 tb/tb_universal_shift_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared types and helpers for the universal shift register
//
// Holds the operation code enum, the burst FSM state enum and a helper that
// tells which operations may run as a multi-step burst.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Only the shift and rotate operations are meaningful when repeated.
    function automatic logic is_shift_op(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
               (op == OP_ROR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// rtl/usr_shift_step.sv - combinational single-position shift/rotate unit
//
// Ports:
//   q       current register contents
//   op      operation code; only shift/rotate codes change the value
//   ser_in  serial fill bit for SHL/SHR
//   next_q  register contents after one step
//   out_bit bit leaving the register on this step (0 for non-shift codes)
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  op_e              op,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit
);

    always_comb begin
        next_q  = q;
        out_bit = 1'b0;
        case (op)
            OP_SHL: begin
                next_q  = {q[WIDTH-2:0], ser_in};
                out_bit = q[WIDTH-1];
            end
            OP_SHR: begin
                next_q  = {ser_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ROL: begin
                next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            OP_ROR: begin
                next_q  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            OP_ASR: begin
                next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                next_q  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - parametrised universal shift register with burst shifts
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   enable       command qualifier
//   op           operation code (usr_pkg::op_e)
//   start        run a shift/rotate op as a burst of `amount` steps
//   amount       burst step count, clamped to WIDTH
//   D            parallel load data
//   ser_in       serial fill bit, sampled on every shift edge
//   Q            register contents
//   ser_out      last bit shifted or rotated out
//   busy         burst in progress
//   done         one-cycle pulse after a burst completes
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] D,
    input  logic             ser_in,
    output logic [WIDTH-1:0] Q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ser_q, ser_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              bop_q, bop_d;

    op_e              cmd_op;
    op_e              step_op;
    logic [WIDTH-1:0] step_q;
    logic             step_bit;
    logic [CNT_W-1:0] n_amt;

    assign cmd_op = op_e'(op);
    // During a burst the step unit must follow the latched op, not the live port.
    assign step_op = (state_q == ST_SHIFT) ? bop_q : cmd_op;
    assign n_amt   = (amount > WIDTH_C) ? WIDTH_C : amount;

    usr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (q_q),
        .op      (step_op),
        .ser_in  (ser_in),
        .next_q  (step_q),
        .out_bit (step_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            ser_q   <= 1'b0;
            cnt_q   <= '0;
            bop_q   <= OP_HOLD;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            ser_q   <= ser_d;
            cnt_q   <= cnt_d;
            bop_q   <= bop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        ser_d   = ser_q;
        cnt_d   = cnt_q;
        bop_d   = bop_q;

        case (state_q)
            ST_SHIFT: begin
                q_d   = step_q;
                ser_d = step_bit;
                cnt_d = cnt_q - ONE_C;
                if (cnt_q == ONE_C) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept commands; DONE falls back to IDLE
                // unless a new burst is accepted in the same cycle.
                state_d = ST_IDLE;
                if (enable) begin
                    if (start && is_shift_op(cmd_op)) begin
                        if (n_amt == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            q_d   = step_q;
                            ser_d = step_bit;
                            if (n_amt == ONE_C) begin
                                state_d = ST_DONE;
                            end else begin
                                bop_d   = cmd_op;
                                cnt_d   = n_amt - ONE_C;
                                state_d = ST_SHIFT;
                            end
                        end
                    end else begin
                        case (cmd_op)
                            OP_HOLD: ;
                            OP_LOAD: q_d = D;
                            OP_CLR: begin
                                q_d   = '0;
                                ser_d = 1'b0;
                            end
                            default: begin
                                q_d   = step_q;
                                ser_d = step_bit;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    assign Q       = q_q;
    assign ser_out = ser_q;
    assign busy    = (state_q == ST_SHIFT);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg
module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int M  = 256;
    localparam int H  = 128;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [2:0]    op;
    logic          start;
    logic [CW-1:0] amount;
    logic [W-1:0]  D;
    logic          ser_in;
    logic [W-1:0]  Q;
    logic          ser_out;
    logic          busy;
    logic          done;

    universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .op      (op),
        .start   (start),
        .amount  (amount),
        .D       (D),
        .ser_in  (ser_in),
        .Q       (Q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          en;
        logic [2:0]    op;
        logic          st;
        logic [CW-1:0] amt;
        logic [W-1:0]  d;
        logic          si;
        logic [W-1:0]  eq;
        logic          es;
        logic          eb;
        logic          ed;
    } vec_t;

    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model: value as integer, burst as "steps still owed".
    int m_q, m_ser, m_rem, m_bop, m_done;

    function automatic vec_t mk(input logic rst, input logic en, input logic [2:0] o,
                                input logic st, input logic [CW-1:0] amt, input logic [W-1:0] d,
                                input logic si, input logic [W-1:0] eq, input logic es,
                                input logic eb, input logic ed);
        vec_t v;
        v.rst = rst; v.en = en; v.op = o; v.st = st; v.amt = amt; v.d = d; v.si = si;
        v.eq = eq; v.es = es; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic mstep(input int o, input int si, input int d);
        int b;
        case (o)
            1: m_q = d;
            2: begin b = m_q / H; m_q = (m_q * 2) % M + si; m_ser = b; end
            3: begin b = m_q % 2; m_q = m_q / 2 + si * H; m_ser = b; end
            4: begin b = m_q / H; m_q = (m_q * 2) % M + b; m_ser = b; end
            5: begin b = m_q % 2; m_q = m_q / 2 + b * H; m_ser = b; end
            6: begin b = m_q % 2; m_q = m_q / 2 + ((m_q >= H) ? H : 0); m_ser = b; end
            7: begin m_q = 0; m_ser = 0; end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        int n;
        if (reset) begin
            m_q = 0; m_ser = 0; m_rem = 0; m_done = 0;
        end else if (m_rem > 0) begin
            mstep(m_bop, int'(ser_in), int'(D));
            m_rem--;
            m_done = (m_rem == 0) ? 1 : 0;
        end else begin
            m_done = 0;
            if (enable) begin
                if (start && op >= 3'd2 && op <= 3'd6) begin
                    n = (int'(amount) > W) ? W : int'(amount);
                    if (n == 0) begin
                        m_done = 1;
                    end else begin
                        mstep(int'(op), int'(ser_in), int'(D));
                        m_rem  = n - 1;
                        m_bop  = int'(op);
                        m_done = (n == 1) ? 1 : 0;
                    end
                end else begin
                    mstep(int'(op), int'(ser_in), int'(D));
                end
            end
        end
    endtask

    task automatic apply(input logic rst, input logic en, input logic [2:0] o, input logic st,
                         input logic [CW-1:0] amt, input logic [W-1:0] d, input logic si);
        reset = rst; enable = en; op = o; start = st; amount = amt; D = d; ser_in = si;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; op = 3'd0; start = 1'b0; amount = '0; D = '0; ser_in = 1'b0;
        m_q = 0; m_ser = 0; m_rem = 0; m_bop = 0; m_done = 0;

        //                 rst en  op   st amt    D      si   Q      so  bsy dn
        tbl.push_back(mk(1, 1, 3'd4, 1, 4'd5,  8'hE7, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd1, 0, 4'd0,  8'hA5, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3'd1, 0, 4'd0,  8'h3C, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd7, 0, 4'd0,  8'h00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd1, 0, 4'd0,  8'hA5, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd2, 0, 4'd0,  8'h00, 1, 8'h4B, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd1, 0, 4'd0,  8'h85, 0, 8'h85, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd6, 0, 4'd0,  8'h00, 0, 8'hC2, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd1, 0, 4'd0,  8'h81, 0, 8'h81, 1, 0, 0));
        // ROL burst of 3; op/D churn while busy
        tbl.push_back(mk(0, 1, 3'd4, 1, 4'd3,  8'h00, 0, 8'h03, 1, 1, 0));
        tbl.push_back(mk(0, 1, 3'd1, 1, 4'd7,  8'hFF, 1, 8'h06, 0, 1, 0));
        tbl.push_back(mk(0, 1, 3'd7, 0, 4'd0,  8'hFF, 1, 8'h0C, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h0C, 0, 0, 0));
        // SHR burst, amount 12 clamped to 8
        tbl.push_back(mk(0, 1, 3'd1, 0, 4'd0,  8'hFF, 0, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd3, 1, 4'd12, 8'h00, 0, 8'h7F, 1, 1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h3F, 1, 1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h1F, 1, 1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h0F, 1, 1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h07, 1, 1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h03, 1, 1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h01, 1, 1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h00, 1, 0, 1));
        tbl.push_back(mk(0, 1, 3'd0, 0, 4'd0,  8'h00, 0, 8'h00, 1, 0, 0));
        // zero-length burst
        tbl.push_back(mk(0, 1, 3'd1, 0, 4'd0,  8'h5A, 0, 8'h5A, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd5, 1, 4'd0,  8'h00, 0, 8'h5A, 1, 0, 1));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h5A, 1, 0, 0));
        // back-to-back bursts
        tbl.push_back(mk(0, 1, 3'd1, 0, 4'd0,  8'h01, 0, 8'h01, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd4, 1, 4'd2,  8'h00, 0, 8'h02, 0, 1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h04, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3'd2, 1, 4'd2,  8'h00, 1, 8'h09, 0, 1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 1, 8'h13, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h13, 0, 0, 0));
        // reset mid-burst
        tbl.push_back(mk(0, 1, 3'd1, 0, 4'd0,  8'h81, 0, 8'h81, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd4, 1, 4'd5,  8'h00, 0, 8'h03, 1, 1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h06, 0, 1, 0));
        tbl.push_back(mk(1, 1, 3'd2, 1, 4'd3,  8'hFF, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 4'd0,  8'h00, 0, 8'h00, 0, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].op, tbl[i].st, tbl[i].amt, tbl[i].d, tbl[i].si);
            check($sformatf("vec%0d_Q", i),       int'(Q),       int'(tbl[i].eq));
            check($sformatf("vec%0d_ser_out", i), int'(ser_out), int'(tbl[i].es));
            check($sformatf("vec%0d_busy", i),    int'(busy),    int'(tbl[i].eb));
            check($sformatf("vec%0d_done", i),    int'(done),    int'(tbl[i].ed));
        end

        // Randomised run against the behavioural model.
        for (int k = 0; k < 3000; k++) begin
            apply(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0),
                  CW'($urandom_range(0, 15)),
                  W'($urandom),
                  1'($urandom));
            check("rnd_Q",       int'(Q),       m_q);
            check("rnd_ser_out", int'(ser_out), m_ser);
            check("rnd_busy",    int'(busy),    (m_rem > 0) ? 1 : 0);
            check("rnd_done",    int'(done),    m_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
